// File: rtl/vga_layer_compositor.sv
// vga_layer_compositor: VGA timing generator plus a static-priority compositor
// for LAYER_CNT fixed-latency renderers. Sync/DE are delayed to match the
// renderer latency. Layer mask and mode are captured once per frame. Outputs
// are registered.
module vga_layer_compositor #(
    parameter int          PIX_WIDTH     = 12,
    parameter int          LAYER_CNT     = 2,
    parameter int          LAYER_LATENCY = 1,
    parameter int          H_DISP        = 1280,
    parameter int          H_FPORCH      = 48,
    parameter int          H_SYNC        = 112,
    parameter int          H_BPORCH      = 248,
    parameter int          V_DISP        = 1024,
    parameter int          V_FPORCH      = 1,
    parameter int          V_SYNC        = 3,
    parameter int          V_BPORCH      = 38,
    parameter bit          HS_POL        = 1'b0,
    parameter bit          VS_POL        = 1'b0,
    parameter logic [23:0] BG_COLOR      = 24'h000000,
    parameter int          BAR_SHIFT     = 7
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [LAYER_CNT*24-1:0] layer_data_i,
    input  logic [LAYER_CNT-1:0]    layer_en_i,
    input  logic [LAYER_CNT-1:0]    layer_mask_i,
    input  logic                    mode_i,
    output logic [PIX_WIDTH-1:0]    pix_x_o,
    output logic [PIX_WIDTH-1:0]    pix_y_o,
    output logic                    frame_start_o,
    output logic                    vga_hs_o,
    output logic                    vga_vs_o,
    output logic                    vga_de_o,
    output logic [7:0]              vga_r_o,
    output logic [7:0]              vga_g_o,
    output logic [7:0]              vga_b_o
);
    localparam int H_TOT = H_DISP + H_FPORCH + H_SYNC + H_BPORCH;
    localparam int V_TOT = V_DISP + V_FPORCH + V_SYNC + V_BPORCH;
    localparam logic [PIX_WIDTH-1:0] H_LAST  = PIX_WIDTH'(H_TOT - 1);
    localparam logic [PIX_WIDTH-1:0] V_LAST  = PIX_WIDTH'(V_TOT - 1);
    localparam logic [PIX_WIDTH-1:0] H_DE_C  = PIX_WIDTH'(H_DISP);
    localparam logic [PIX_WIDTH-1:0] V_DE_C  = PIX_WIDTH'(V_DISP);
    localparam logic [PIX_WIDTH-1:0] HS_BEG  = PIX_WIDTH'(H_DISP + H_FPORCH);
    localparam logic [PIX_WIDTH-1:0] HS_END  = PIX_WIDTH'(H_DISP + H_FPORCH + H_SYNC);
    localparam logic [PIX_WIDTH-1:0] VS_BEG  = PIX_WIDTH'(V_DISP + V_FPORCH);
    localparam logic [PIX_WIDTH-1:0] VS_END  = PIX_WIDTH'(V_DISP + V_FPORCH + V_SYNC);
    localparam logic [PIX_WIDTH-1:0] ZERO    = {PIX_WIDTH{1'b0}};
    localparam logic [PIX_WIDTH-1:0] ONE     = {{(PIX_WIDTH-1){1'b0}}, 1'b1};

    // Timing tap layout: {frame_start, de, vs, hs, bar[2:0]}. Only the
    // x bits that select a test bar are needed after the delay line.
    localparam int             TAP_W    = 7;
    localparam logic [TAP_W-1:0] TAP_IDLE = {1'b0, 1'b0, ~VS_POL, ~HS_POL, 3'b000};

    // Colour-bar palette, bar 0 at the left.
    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            3'd7:    c = 24'h000000;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    logic                 run_q, run_d;
    logic [PIX_WIDTH-1:0] h_q, h_d, v_q, v_d;
    logic                 fs_q, fs_d;
    logic                 tim_de_s, tim_hs_s, tim_vs_s;
    logic [TAP_W-1:0]     tim_s, mix_s;

    // run_q holds the counters at (0,0) for one cycle after reset so that the
    // first frame_start pulse lands on pixel (0,0).
    always_comb begin
        run_d = 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        fs_d  = 1'b0;
        if (!run_q) begin
            h_d  = ZERO;
            v_d  = ZERO;
            fs_d = 1'b1;
        end else begin
            if (h_q == H_LAST) begin
                h_d = ZERO;
                if (v_q == V_LAST) begin
                    v_d = ZERO;
                end else begin
                    v_d = v_q + ONE;
                end
            end else begin
                h_d = h_q + ONE;
            end
            fs_d = (h_d == ZERO) && (v_d == ZERO);
        end
    end

    // Timing counter and frame-start registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            run_q <= 1'b0;
            h_q   <= ZERO;
            v_q   <= ZERO;
            fs_q  <= 1'b0;
        end else begin
            run_q <= run_d;
            h_q   <= h_d;
            v_q   <= v_d;
            fs_q  <= fs_d;
        end
    end

    // Undelayed sync/DE decode; everything is inactive during the post-reset hold cycle.
    always_comb begin
        tim_de_s = run_q && (h_q < H_DE_C) && (v_q < V_DE_C);
        if (run_q && (h_q >= HS_BEG) && (h_q < HS_END)) begin
            tim_hs_s = HS_POL;
        end else begin
            tim_hs_s = ~HS_POL;
        end
        if (run_q && (v_q >= VS_BEG) && (v_q < VS_END)) begin
            tim_vs_s = VS_POL;
        end else begin
            tim_vs_s = ~VS_POL;
        end
        tim_s = {fs_q, tim_de_s, tim_vs_s, tim_hs_s, h_q[BAR_SHIFT+2:BAR_SHIFT]};
    end

    generate
        if (LAYER_LATENCY == 0) begin : g_nodly
            assign mix_s = tim_s;
        end else begin : g_dly
            logic [TAP_W-1:0] dly_q [LAYER_LATENCY];
            // Delay line matching the renderer latency.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    for (int i = 0; i < LAYER_LATENCY; i++) begin
                        dly_q[i] <= TAP_IDLE;
                    end
                end else begin
                    dly_q[0] <= tim_s;
                    for (int i = 1; i < LAYER_LATENCY; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end
            assign mix_s = dly_q[LAYER_LATENCY-1];
        end
    endgenerate

    logic                 mix_fs_s, mix_de_s, mix_vs_s, mix_hs_s;
    logic [2:0]           mix_bar_s;
    logic [LAYER_CNT-1:0] mask_q, mask_d;
    logic                 mode_q, mode_d;
    logic [LAYER_CNT-1:0] cand_s;
    logic                 seen_s;
    logic [23:0]          lay_rgb_s, rgb_d, rgb_q;
    logic                 hs_q, vs_q, de_q;

    assign {mix_fs_s, mix_de_s, mix_vs_s, mix_hs_s, mix_bar_s} = mix_s;

    // Frame-coherent shadows: pixel (0,0) already sees the freshly sampled values.
    always_comb begin
        if (mix_fs_s) begin
            mask_d = layer_mask_i;
            mode_d = mode_i;
        end else begin
            mask_d = mask_q;
            mode_d = mode_q;
        end
    end

    // Priority pick: the lowest-index enabled, unmasked layer wins.
    always_comb begin
        cand_s    = layer_en_i & mask_d;
        seen_s    = 1'b0;
        lay_rgb_s = 24'h000000;
        for (int k = 0; k < LAYER_CNT; k++) begin
            lay_rgb_s = lay_rgb_s | ({24{cand_s[k] & ~seen_s}} & layer_data_i[24*k +: 24]);
            seen_s    = seen_s | cand_s[k];
        end
        if (!mix_de_s) begin
            rgb_d = 24'h000000;
        end else if (mode_d) begin
            rgb_d = bar_color(mix_bar_s);
        end else if (seen_s) begin
            rgb_d = lay_rgb_s;
        end else begin
            rgb_d = BG_COLOR;
        end
    end

    // Output and shadow registers of the mix stage.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mask_q <= {LAYER_CNT{1'b1}};
            mode_q <= 1'b0;
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            de_q   <= 1'b0;
            rgb_q  <= 24'h000000;
        end else begin
            mask_q <= mask_d;
            mode_q <= mode_d;
            hs_q   <= mix_hs_s;
            vs_q   <= mix_vs_s;
            de_q   <= mix_de_s;
            rgb_q  <= rgb_d;
        end
    end

    assign pix_x_o       = h_q;
    assign pix_y_o       = v_q;
    assign frame_start_o = fs_q;
    assign vga_hs_o      = hs_q;
    assign vga_vs_o      = vs_q;
    assign vga_de_o      = de_q;
    assign vga_r_o       = rgb_q[23:16];
    assign vga_g_o       = rgb_q[15:8];
    assign vga_b_o       = rgb_q[7:0];
endmodule

// File: doc/vga_layer_compositor.md
Name: vga_layer_compositor

Overview:
- Parametrised successor to the fixed two-layer tetris drawing top.
- Generates VGA timing internally and broadcasts pixel coordinates to LAYER_CNT renderers.
- Renderers have a fixed latency. The block composites their outputs by static priority, aligns sync and DE to that latency, and registers the VGA output.
- Adds frame-coherent layer masking and a built-in colour-bar test mode.

Parameters:
- PIX_WIDTH, 12, width of h/v counters and coordinate outputs
- LAYER_CNT, 2, number of renderer layers (1..8); index 0 is highest priority
- LAYER_LATENCY, 1, renderer latency in cycles from pix_x_o/pix_y_o to layer_data_i (0..8)
- H_DISP, 1280; H_FPORCH, 48; H_SYNC, 112; H_BPORCH, 248: horizontal timing in pixels
- V_DISP, 1024; V_FPORCH, 1; V_SYNC, 3; V_BPORCH, 38: vertical timing in lines
- HS_POL, 0; VS_POL, 0: sync active level
- BG_COLOR, 24'h000000: colour when no layer is enabled
- BAR_SHIFT, 7: log2 of test-bar width in pixels

Ports:
- clk_i  in  1  pixel clock
- rst_n_i  in  1  reset, asynchronous, active-low
- layer_data_i  in  LAYER_CNT*24  per-layer RGB888, layer k at bits [24k+23:24k]
- layer_en_i  in  LAYER_CNT  per-layer pixel-valid
- layer_mask_i  in  LAYER_CNT  1 = layer allowed; sampled once per frame
- mode_i  in  1  0 = composite, 1 = colour bars; sampled once per frame
- pix_x_o  out  PIX_WIDTH  horizontal counter
- pix_y_o  out  PIX_WIDTH  vertical counter
- frame_start_o  out  1  one-cycle pulse when counters are at (0,0)
- vga_hs_o, vga_vs_o, vga_de_o  out  1 each  aligned sync and data enable
- vga_r_o, vga_g_o, vga_b_o  out  8 each  colour

Behaviour:
- Reset is asynchronous, active-low, applied in every state:
  - counters = 0; frame_start_o = 0.
  - hs = ~HS_POL, vs = ~VS_POL; de = 0; rgb = 0.
  - Entire delay line flushed to these inactive values.
  - Mask shadow = all ones; mode shadow = 0.
- Timing counters:
  - H_TOT = sum of the four horizontal parameters; V_TOT likewise.
  - h counts 0..H_TOT-1 and wraps to 0. v increments on each h wrap and wraps to 0 after V_TOT-1.
  - pix_x_o = h, pix_y_o = v, both registered and driven in every region including blanking.
- Timing-stage (undelayed) signals:
  - de = (h < H_DISP) && (v < V_DISP).
  - hs active for H_DISP+H_FPORCH <= h < H_DISP+H_FPORCH+H_SYNC.
  - vs active for V_DISP+V_FPORCH <= v < V_DISP+V_FPORCH+V_SYNC; it changes on the h wrap, with no half-line offset.
- frame_start_o is high exactly in the cycle where pix_x_o = 0 and pix_y_o = 0.
- Alignment:
  - hs, vs, de, frame_start and pix_x are delayed LAYER_LATENCY cycles to the mix stage, where they line up with layer_data_i.
  - The mix stage registers all outputs: end-to-end latency from pix_x_o to vga_* is LAYER_LATENCY+1.
- Shadow registers:
  - In the cycle the delayed frame_start is high at the mix stage, layer_mask_i and mode_i are captured into shadows.
  - That same pixel (0,0) already uses the new values.
  - Mid-frame input changes have no effect until the next frame.
- Mixing:
  - Candidate layer k is layer_en_i[k] && mask_shadow[k].
  - Output is the lowest-index candidate's data, or BG_COLOR if there is none.
  - In mode 1, layers are ignored and the colour comes from bar = x_delayed[BAR_SHIFT+2:BAR_SHIFT].
  - Bar index 0..7 maps to: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- When delayed de = 0, rgb = 0 regardless of layers or mode.

Test Plan:
Common setup: H_DISP=8, H_FPORCH=2, H_SYNC=2, H_BPORCH=2, V_DISP=4, V_FPORCH=1, V_SYNC=1, V_BPORCH=1, LAYER_CNT=3, LAYER_LATENCY=2, BAR_SHIFT=0.
- Timing:
  - Stimulus: release reset, run 2 frames.
  - Required: frame_start_o every 98 cycles; pix_x_o wraps 13->0.
  - Required: vga_hs_o low for 2 cycles, beginning 3 cycles after pix_x_o=10.
  - Required: vga_de_o high 8 cycles per line for lines 0..3 only.
- Priority:
  - Stimulus: layer_en=3'b110, data1=123456, data2=ABCDEF.
  - Required: vga rgb = 12,34,56 for pixels in active area.
  - Stimulus: then en=000.
  - Required: rgb = BG_COLOR.
- Mask coherence:
  - Stimulus: change layer_mask_i 111->101 mid-frame, en=010.
  - Required: layer 1 keeps being displayed until the next frame's pixel (0,0), then BG from that pixel.
- Colour bars:
  - Stimulus: mode_i=1 set before a frame.
  - Required: pixels x=0..7 of line 0 output FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- Blanking:
  - Stimulus: layer_en=111 constantly.
  - Required: rgb=0 whenever vga_de_o=0.
- Reset mid-line:
  - Stimulus: assert rst_n_i at pix_x_o=5, asynchronously.
  - Required: outputs go to reset values without a clock edge.
  - Required: after release, the first frame_start_o pulse comes 1 cycle later and the line/frame restart from (0,0).
